mm_writeback: RTL and testbench

//  Downstream stage of the matrix-multiply controller. Takes each 512-bit result row and its

---
 rtl/mm_writeback_if.sv | 34 +++
 rtl/mm_writeback.sv | 205 ++++++++++++++++++++
 tb/tb_mm_writeback.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mm_writeback_if.sv
// mm_writeback_if
//  Groups the result-row input and the output-buffer write port of the
//  matrix-multiply writeback stage.
//  Signals:
//   in_data_valid / in_data : result row from the multiply array
//   in_addr_valid / in_addr : destination row address in the output buffer
//   buf_wr_req/addr/data    : write request towards the output buffer
//   buf_wr_gnt              : output buffer accepts the request this cycle
//  Modports:
//   master : upstream producer plus output buffer (drives rows and gnt)
//   slave  : the writeback stage itself
interface mm_writeback_if #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 11
);
  logic              in_data_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_addr_valid;
  logic [ADDR_W-1:0] in_addr;
  logic              buf_wr_req;
  logic [ADDR_W-1:0] buf_wr_addr;
  logic [DATA_W-1:0] buf_wr_data;
  logic              buf_wr_gnt;

  modport master (
    output in_data_valid, in_data, in_addr_valid, in_addr, buf_wr_gnt,
    input  buf_wr_req, buf_wr_addr, buf_wr_data
  );

  modport slave (
    input  in_data_valid, in_data, in_addr_valid, in_addr, buf_wr_gnt,
    output buf_wr_req, buf_wr_addr, buf_wr_data
  );
endinterface

// File: rtl/mm_writeback.sv
// mm_writeback
//  Downstream stage of the matrix-multiply controller. Each accepted result
//  row gets a per-lane signed bias added, is saturated to 16 bits, optionally
//  passed through ReLU, and is queued in a small fall-through FIFO that
//  drains to the output buffer over a req/gnt port. Accepted writes are
//  counted and done pulses once the layer's expected count is reached.
//  Ports:
//   clk, rstn        : clock (rising edge), asynchronous active-low reset
//   start            : begin a layer (IDLE only); latches relu_en, expected_writes
//   bias_load/data   : load the per-lane bias register (IDLE only)
//   bus              : row input and output-buffer write port (slave side)
//   busy, done       : state != IDLE; one-cycle completion pulse
//   wr_count         : writes accepted this layer
//   err_overflow     : sticky, a row was dropped because the FIFO was full
//   err_align        : sticky, data-valid and addr-valid disagreed in RUN
module mm_writeback #(
  parameter int DATA_W     = 512,
  parameter int LANE_W     = 16,
  parameter int ADDR_W     = 11,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 24
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              relu_en,
  input  logic [CNT_W-1:0]  expected_writes,
  input  logic              bias_load,
  input  logic [DATA_W-1:0] bias_data,
  mm_writeback_if.slave     bus,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  wr_count,
  output logic              err_overflow,
  output logic              err_align
);

  localparam int LANES = DATA_W / LANE_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [LANE_W-1:0] LANE_MAX = {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0] LANE_MIN = {1'b1, {(LANE_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t state, state_next;

  logic              relu_q;
  logic [CNT_W-1:0]  expected_q;
  logic [DATA_W-1:0] bias_q;

  logic                         s1_valid;
  logic [ADDR_W-1:0]            s1_addr;
  logic [LANES-1:0][LANE_W:0]   s1_sum;
  logic [LANES-1:0][LANE_W:0]   s1_sum_next;

  logic              s2_valid;
  logic [ADDR_W-1:0] s2_addr;
  logic [DATA_W-1:0] s2_data;
  logic [DATA_W-1:0] s2_data_next;

  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [PTR_W:0]    wptr, rptr;
  logic              fifo_empty, fifo_full, pop, push, drop;

  logic start_take, row_take, row_misalign;

  assign start_take   = (state == IDLE) && start;
  assign row_take     = (state == RUN) && bus.in_data_valid && bus.in_addr_valid;
  assign row_misalign = (state == RUN) && (bus.in_data_valid ^ bus.in_addr_valid);

  // The extra pointer bit tells a full FIFO apart from an empty one.
  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[PTR_W] != rptr[PTR_W]) &&
                      (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);
  assign pop  = !fifo_empty && bus.buf_wr_gnt;
  // A full FIFO still accepts a row when the head leaves in the same cycle.
  assign push = s2_valid && (!fifo_full || pop);
  assign drop = s2_valid && fifo_full && !pop;

  // Empty FIFO drives zeros so the write port is quiet between rows.
  assign bus.buf_wr_req  = !fifo_empty;
  assign bus.buf_wr_addr = fifo_empty ? '0 : fifo_addr[rptr[PTR_W-1:0]];
  assign bus.buf_wr_data = fifo_empty ? '0 : fifo_data[rptr[PTR_W-1:0]];

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Lane-wise bias add in 17 bits so the sum can never wrap.
  always_comb begin
    s1_sum_next = '0;
    for (int i = 0; i < LANES; i++) begin
      s1_sum_next[i] = {bus.in_data[i*LANE_W+LANE_W-1], bus.in_data[i*LANE_W +: LANE_W]} +
                       {bias_q[i*LANE_W+LANE_W-1], bias_q[i*LANE_W +: LANE_W]};
    end
  end

  // Saturate each 17-bit sum back to 16 bits, then clip negatives when ReLU is on.
  always_comb begin
    s2_data_next = '0;
    for (int i = 0; i < LANES; i++) begin
      if (s1_sum[i][LANE_W] != s1_sum[i][LANE_W-1]) begin
        s2_data_next[i*LANE_W +: LANE_W] = s1_sum[i][LANE_W] ? LANE_MIN : LANE_MAX;
      end else begin
        s2_data_next[i*LANE_W +: LANE_W] = s1_sum[i][LANE_W-1:0];
      end
      if (relu_q && s2_data_next[i*LANE_W+LANE_W-1]) begin
        s2_data_next[i*LANE_W +: LANE_W] = '0;
      end
    end
  end

  // Layer configuration and bias register; both only change while IDLE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      relu_q     <= 1'b0;
      expected_q <= '0;
      bias_q     <= '0;
    end else begin
      if (start_take) begin
        relu_q     <= relu_en;
        expected_q <= expected_writes;
      end
      if ((state == IDLE) && bias_load) begin
        bias_q <= bias_data;
      end
    end
  end

  // Two-stage arithmetic pipeline; it never stalls, so overflow is handled at the FIFO.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_sum   <= '0;
      s2_valid <= 1'b0;
      s2_addr  <= '0;
      s2_data  <= '0;
    end else begin
      s1_valid <= row_take;
      s2_valid <= s1_valid;
      if (row_take) begin
        s1_addr <= bus.in_addr;
        s1_sum  <= s1_sum_next;
      end
      if (s1_valid) begin
        s2_addr <= s1_addr;
        s2_data <= s2_data_next;
      end
    end
  end

  // FIFO storage has no reset; the empty flag masks stale entries.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wptr[PTR_W-1:0]] <= s2_data;
      fifo_addr[wptr[PTR_W-1:0]] <= s2_addr;
    end
  end

  // FIFO pointers, write counter and sticky error flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr         <= '0;
      rptr         <= '0;
      wr_count     <= '0;
      err_overflow <= 1'b0;
      err_align    <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (start_take) begin
        wr_count     <= '0;
        err_overflow <= 1'b0;
        err_align    <= 1'b0;
      end else begin
        if (pop)          wr_count     <= wr_count + 1'b1;
        if (drop)         err_overflow <= 1'b1;
        if (row_misalign) err_align    <= 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: RUN ends on the write that brings the count to the expected total.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = (expected_writes == '0) ? DONE : RUN;
      end
      RUN: begin
        if (pop && (CNT_W'(wr_count + 1'b1) == expected_q)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mm_writeback.sv
// tb_mm_writeback
//  Directed layer scenarios with random row and bias contents. Expected
//  writes come from a lane-by-lane integer model of bias, clamp and ReLU.
module tb_mm_writeback;
  localparam int DATA_W = 512;
  localparam int LANE_W = 16;
  localparam int ADDR_W = 11;
  localparam int CNT_W  = 24;
  localparam int LANES  = DATA_W / LANE_W;

  logic              clk;
  logic              rstn;
  logic              start;
  logic              relu_en;
  logic [CNT_W-1:0]  expected_writes;
  logic              bias_load;
  logic [DATA_W-1:0] bias_data;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  wr_count;
  logic              err_overflow;
  logic              err_align;

  mm_writeback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mm_writeback #(
    .DATA_W(DATA_W), .LANE_W(LANE_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(8), .CNT_W(CNT_W)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .start           (start),
    .relu_en         (relu_en),
    .expected_writes (expected_writes),
    .bias_load       (bias_load),
    .bias_data       (bias_data),
    .bus             (bus),
    .busy            (busy),
    .done            (done),
    .wr_count        (wr_count),
    .err_overflow    (err_overflow),
    .err_align       (err_align)
  );

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  int cyc           = 0;
  int first_req_cyc = -1;
  int last_pop_cyc  = -1;
  int done_cnt      = 0;
  int done_cyc      = -1;

  logic [ADDR_W-1:0] obs_addr_q [$];
  logic [DATA_W-1:0] obs_data_q [$];
  logic [ADDR_W-1:0] exp_addr_q [$];
  logic [DATA_W-1:0] exp_data_q [$];

  logic [DATA_W-1:0] bias_model;
  logic              relu_model;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Write-port monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.buf_wr_req && first_req_cyc < 0) first_req_cyc = cyc;
    if (bus.buf_wr_req && bus.buf_wr_gnt) begin
      obs_addr_q.push_back(bus.buf_wr_addr);
      obs_data_q.push_back(bus.buf_wr_data);
      last_pop_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check_output(input string tag, input logic [DATA_W-1:0] observed,
                              input logic [DATA_W-1:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else begin
      checks_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference: signed lane + signed bias, clamp to 16 bits, optional ReLU.
  function automatic logic [DATA_W-1:0] ref_row(input logic [DATA_W-1:0] row,
                                                input logic [DATA_W-1:0] bias,
                                                input logic relu);
    logic [DATA_W-1:0] r;
    int a, b, s;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      a = int'($signed(row[i*LANE_W +: LANE_W]));
      b = int'($signed(bias[i*LANE_W +: LANE_W]));
      s = a + b;
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      if (relu && s < 0) s = 0;
      r[i*LANE_W +: LANE_W] = s[15:0];
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] rand_row();
    logic [DATA_W-1:0] r;
    for (int k = 0; k < DATA_W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_bias(input logic [DATA_W-1:0] b);
    bias_load = 1'b1;
    bias_data = b;
    tick();
    bias_load  = 1'b0;
    bias_model = b;
  endtask

  task automatic start_layer(input int n, input logic relu);
    start           = 1'b1;
    relu_en         = relu;
    expected_writes = CNT_W'(n);
    relu_model      = relu;
    tick();
    start = 1'b0;
  endtask

  // One-cycle row; the model queue records it unless the row is expected to drop.
  task automatic send_row(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                          input logic keep);
    bus.in_data_valid = 1'b1;
    bus.in_addr_valid = 1'b1;
    bus.in_addr       = addr;
    bus.in_data       = data;
    tick();
    bus.in_data_valid = 1'b0;
    bus.in_addr_valid = 1'b0;
    if (keep) begin
      exp_addr_q.push_back(addr);
      exp_data_q.push_back(ref_row(data, bias_model, relu_model));
    end
  endtask

  task automatic wait_writes(input int n, input string tag);
    int budget;
    budget = 200;
    while (obs_addr_q.size() < n && budget > 0) begin
      tick();
      budget--;
    end
    check_output({tag, "_write_timeout"}, DATA_W'(obs_addr_q.size() >= n), 1);
  endtask

  task automatic wait_done(input int target, input string tag);
    int budget;
    budget = 200;
    while (done_cnt < target && budget > 0) begin
      tick();
      budget--;
    end
    check_output({tag, "_done_timeout"}, DATA_W'(done_cnt >= target), 1);
    tick();
    tick();
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check_output({tag, "_nwrites"}, obs_addr_q.size(), exp_addr_q.size());
    n = (obs_addr_q.size() < exp_addr_q.size()) ? obs_addr_q.size() : exp_addr_q.size();
    for (int i = 0; i < n; i++) begin
      check_output($sformatf("%s_addr%0d", tag, i), obs_addr_q[i], exp_addr_q[i]);
      check_output($sformatf("%s_data%0d", tag, i), obs_data_q[i], exp_data_q[i]);
    end
    obs_addr_q.delete();
    obs_data_q.delete();
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  initial begin
    logic [DATA_W-1:0] row, b, w;
    int t0, dc;

    rstn              = 1'b0;
    start             = 1'b0;
    relu_en           = 1'b0;
    expected_writes   = '0;
    bias_load         = 1'b0;
    bias_data         = '0;
    bias_model        = '0;
    relu_model        = 1'b0;
    bus.in_data_valid = 1'b0;
    bus.in_addr_valid = 1'b0;
    bus.in_data       = '0;
    bus.in_addr       = '0;
    bus.buf_wr_gnt    = 1'b0;

    // Reset state
    repeat (3) tick();
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_req", bus.buf_wr_req, 0);
    check_output("rst_data", bus.buf_wr_data, 0);
    check_output("rst_wr_count", wr_count, 0);
    check_output("rst_err_overflow", err_overflow, 0);
    check_output("rst_err_align", err_align, 0);
    rstn = 1'b1;
    tick();

    // Scenario 1: plain pass-through, four rows, gnt tied high
    $display("[TB] scenario 1: four rows, latency and done");
    bus.buf_wr_gnt = 1'b1;
    load_bias('0);
    done_cnt = 0;
    first_req_cyc = -1;
    start_layer(4, 1'b0);
    check_output("t1_busy", busy, 1);
    t0 = cyc;
    for (int i = 0; i < 4; i++) send_row(ADDR_W'(16 + i), rand_row(), 1'b1);
    wait_writes(4, "t1");
    check_output("t1_latency", DATA_W'(first_req_cyc - t0), 3);
    wait_done(1, "t1");
    check_output("t1_done_cycle", DATA_W'(done_cyc - last_pop_cyc), 1);
    check_output("t1_done_count", done_cnt, 1);
    check_output("t1_wr_count", wr_count, 4);
    check_output("t1_busy_end", busy, 0);
    compare_writes("t1");

    // Scenario 2: saturation in both directions, then ReLU
    $display("[TB] scenario 2: saturation and relu");
    b = rand_row();
    b[15:0]  = 16'h0020;
    b[31:16] = 16'hFFF0;
    load_bias(b);
    row = rand_row();
    row[15:0]  = 16'h7FF0;
    row[31:16] = 16'h8005;
    start_layer(1, 1'b0);
    send_row(11'h055, row, 1'b1);
    wait_writes(1, "t2a");
    w = obs_data_q[0];
    check_output("t2a_lane0_sat_hi", w[15:0], 16'h7FFF);
    check_output("t2a_lane1_sat_lo", w[31:16], 16'h8000);
    wait_done(2, "t2a");
    compare_writes("t2a");
    start_layer(1, 1'b1);
    send_row(11'h056, row, 1'b1);
    wait_writes(1, "t2b");
    w = obs_data_q[0];
    check_output("t2b_lane0_sat_hi", w[15:0], 16'h7FFF);
    check_output("t2b_lane1_relu", w[31:16], 16'h0000);
    wait_done(3, "t2b");
    compare_writes("t2b");

    // Scenario 3: stalled write port, ninth row overflows
    $display("[TB] scenario 3: overflow with gnt held low");
    load_bias(rand_row());
    bus.buf_wr_gnt = 1'b0;
    start_layer(8, 1'($urandom_range(1)));
    for (int i = 0; i < 9; i++) send_row(ADDR_W'(32 + i), rand_row(), i < 8);
    repeat (4) tick();
    check_output("t3_err_overflow", err_overflow, 1);
    check_output("t3_req_stalled", bus.buf_wr_req, 1);
    check_output("t3_head_addr", bus.buf_wr_addr, 11'h020);
    check_output("t3_no_writes", wr_count, 0);
    bus.buf_wr_gnt = 1'b1;
    wait_writes(8, "t3");
    wait_done(4, "t3");
    check_output("t3_wr_count", wr_count, 8);
    check_output("t3_overflow_sticky", err_overflow, 1);
    compare_writes("t3");

    // Scenario 4: push into a full FIFO while the head is granted
    $display("[TB] scenario 4: full FIFO push with pop");
    bus.buf_wr_gnt = 1'b0;
    start_layer(9, 1'b0);
    check_output("t4_overflow_cleared", err_overflow, 0);
    for (int i = 0; i < 8; i++) send_row(ADDR_W'(64 + i), rand_row(), 1'b1);
    repeat (4) tick();
    send_row(ADDR_W'(72), rand_row(), 1'b1);
    tick();
    bus.buf_wr_gnt = 1'b1;
    tick();
    bus.buf_wr_gnt = 1'b0;
    repeat (3) tick();
    check_output("t4_no_overflow", err_overflow, 0);
    check_output("t4_one_write", obs_addr_q.size(), 1);
    bus.buf_wr_gnt = 1'b1;
    wait_writes(9, "t4");
    wait_done(5, "t4");
    check_output("t4_wr_count", wr_count, 9);
    compare_writes("t4");

    // Scenario 5: misaligned valids, bias_load outside IDLE, empty layer
    $display("[TB] scenario 5: alignment error and empty layer");
    start_layer(1, 1'b0);
    bus.in_data_valid = 1'b1;
    bus.in_addr_valid = 1'b0;
    bus.in_data       = rand_row();
    bus.in_addr       = 11'h100;
    bias_load         = 1'b1;
    bias_data         = rand_row();
    tick();
    bus.in_data_valid = 1'b0;
    bias_load         = 1'b0;
    repeat (5) tick();
    check_output("t5_err_align", err_align, 1);
    check_output("t5_no_write", obs_addr_q.size(), 0);
    check_output("t5_busy", busy, 1);
    send_row(11'h101, rand_row(), 1'b1);
    wait_writes(1, "t5");
    wait_done(6, "t5");
    check_output("t5_align_sticky", err_align, 1);
    compare_writes("t5");
    start_layer(0, 1'b0);
    check_output("t5_zero_done", done, 1);
    check_output("t5_align_cleared", err_align, 0);
    tick();
    check_output("t5_zero_done_end", done, 0);
    check_output("t5_zero_idle", busy, 0);
    tick();

    // Scenario 6: reset in the middle of a layer, then a fresh layer
    $display("[TB] scenario 6: reset mid-layer");
    start_layer(5, 1'b0);
    for (int i = 0; i < 5; i++) send_row(ADDR_W'(128 + i), rand_row(), 1'b1);
    check_output("t6_two_written", obs_addr_q.size(), 2);
    dc = done_cnt;
    rstn = 1'b0;
    #1;
    check_output("t6_rst_req", bus.buf_wr_req, 0);
    check_output("t6_rst_data", bus.buf_wr_data, 0);
    check_output("t6_rst_addr", bus.buf_wr_addr, 0);
    check_output("t6_rst_wr_count", wr_count, 0);
    check_output("t6_rst_busy", busy, 0);
    tick();
    rstn = 1'b1;
    bias_model = '0;
    repeat (6) tick();
    check_output("t6_fifo_empty", bus.buf_wr_req, 0);
    check_output("t6_no_late_writes", obs_addr_q.size(), 2);
    check_output("t6_no_done", done_cnt, dc);
    obs_addr_q.delete();
    obs_data_q.delete();
    exp_addr_q.delete();
    exp_data_q.delete();
    start_layer(1, 1'b0);
    send_row(11'h3FF, rand_row(), 1'b1);
    wait_writes(1, "t6");
    wait_done(dc + 1, "t6");
    check_output("t6_wr_count", wr_count, 1);
    compare_writes("t6");

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
